// File: rtl/psum_accum_requant_pkg.sv
`default_nettype none
// ============================================================================
// Module   : psum_accum_requant_pkg
// Brief    : Shared widths, FSM state encoding and helpers for the psum
//            accumulate / requantise block.
// Revision : 1.0 - initial release
// ============================================================================
package psum_accum_requant_pkg;

    localparam int NCOL    = 8;
    localparam int IW      = 19;
    localparam int AW      = 32;
    localparam int DEPTH   = 16;
    localparam int MW      = 16;
    localparam int RW      = $clog2(DEPTH + 1);
    localparam int AIW     = $clog2(DEPTH);
    localparam int PW      = AW + MW + 1;
    localparam int PASS_W  = 8;
    localparam int SHIFT_W = 5;
    localparam int OUT_W   = 8;
    localparam int SAT_MAX = 127;
    localparam int SAT_MIN = -128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic logic [AW-1:0] sext_psum(input logic [IW-1:0] v);
        return {{(AW-IW){v[IW-1]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/psum_accum_requant_if.sv
`default_nettype none
// ============================================================================
// Module   : psum_accum_requant_if
// Brief    : Config, psum input, output stream and status signals of the
//            psum accumulate / requantise block.
// Revision : 1.0 - initial release
// ============================================================================
interface psum_accum_requant_if;
    import psum_accum_requant_pkg::*;

    logic                    cfg_start;
    logic [RW-1:0]           cfg_rows;
    logic [PASS_W-1:0]       cfg_passes;
    logic [MW-1:0]           cfg_mult;
    logic [SHIFT_W-1:0]      cfg_shift;
    logic                    cfg_relu;
    logic                    psum_vld;
    logic [NCOL*IW-1:0]      psum_i;
    logic                    out_vld;
    logic                    out_rdy;
    logic [NCOL*OUT_W-1:0]   out_data;
    logic                    busy;
    logic                    done;
    logic                    sat_flag;
    logic                    err_flag;

    modport master (
        output cfg_start, cfg_rows, cfg_passes, cfg_mult, cfg_shift, cfg_relu,
        output psum_vld, psum_i, out_rdy,
        input  out_vld, out_data, busy, done, sat_flag, err_flag
    );

    modport slave (
        input  cfg_start, cfg_rows, cfg_passes, cfg_mult, cfg_shift, cfg_relu,
        input  psum_vld, psum_i, out_rdy,
        output out_vld, out_data, busy, done, sat_flag, err_flag
    );

endinterface
`default_nettype wire

// File: rtl/psum_accum_requant_lane.sv
`default_nettype none
// ============================================================================
// Module   : requant_lane
// Brief    : One column of the drain pipeline: S1 multiply, S2 round/shift,
//            optional ReLU and int8 saturation.
// Revision : 1.0 - initial release
// ============================================================================
module requant_lane
    import psum_accum_requant_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_en,
    input  logic [AW-1:0]       i_acc,
    input  logic [MW-1:0]       i_mult,
    input  logic [SHIFT_W-1:0]  i_shift,
    input  logic                i_relu,
    output logic [OUT_W-1:0]    o_data,
    output logic                o_sat
);

    localparam logic signed [PW-1:0] c_SAT_MAX = PW'(SAT_MAX);
    localparam logic signed [PW-1:0] c_SAT_MIN = PW'(SAT_MIN);
    localparam logic signed [PW-1:0] c_ONE     = PW'(1);

    logic signed [PW-1:0] w_acc_x;
    logic signed [PW-1:0] w_mult_x;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] r_prod;
    logic signed [PW-1:0] w_bias;
    logic signed [PW-1:0] w_sum;
    logic signed [PW-1:0] w_y;
    logic signed [PW-1:0] w_r;
    logic                 w_hi;
    logic                 w_lo;
    logic [OUT_W-1:0]     w_data;
    logic [OUT_W-1:0]     r_data;

    // Multiplier is zero-extended so the product is signed x unsigned.
    assign w_acc_x  = {{(PW-AW){i_acc[AW-1]}}, i_acc};
    assign w_mult_x = {{(PW-MW){1'b0}}, i_mult};
    assign w_prod   = w_acc_x * w_mult_x;

    assign w_bias = (i_shift == '0) ? '0 : (c_ONE <<< (i_shift - SHIFT_W'(1)));
    assign w_sum  = r_prod + w_bias;
    assign w_y    = w_sum >>> i_shift;
    assign w_r    = (i_relu && w_y[PW-1]) ? '0 : w_y;
    assign w_hi   = (w_r > c_SAT_MAX);
    assign w_lo   = (w_r < c_SAT_MIN);
    assign w_data = w_hi ? 8'h7F : (w_lo ? 8'h80 : w_r[OUT_W-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod <= '0;
            r_data <= '0;
        end else if (i_en) begin
            r_prod <= w_prod;
            r_data <= w_data;
        end
    end

    assign o_data = r_data;
    assign o_sat  = w_hi || w_lo;

endmodule
`default_nettype wire

// File: rtl/psum_accum_requant.sv
`default_nettype none
// ============================================================================
// Module   : psum_accum_requant
// Brief    : Accumulates systolic-array column psums across K passes in a
//            row buffer, then requantises and drains rows to int8.
// Revision : 1.0 - initial release
// ============================================================================
module psum_accum_requant
    import psum_accum_requant_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    psum_accum_requant_if.slave  bus
);

    state_t                r_state;
    logic [RW-1:0]         r_rows;
    logic [PASS_W-1:0]     r_passes;
    logic [MW-1:0]         r_mult;
    logic [SHIFT_W-1:0]    r_shift;
    logic                  r_relu;
    logic [AIW-1:0]        r_row_cnt;
    logic [PASS_W-1:0]     r_pass_cnt;
    logic [RW-1:0]         r_rd_row;
    logic [RW-1:0]         r_out_cnt;
    logic                  r_s1_vld;
    logic                  r_out_vld;
    logic                  r_done;
    logic                  r_sat;
    logic                  r_err;
    logic [NCOL*AW-1:0]    r_buf [DEPTH];

    logic [NCOL*AW-1:0]    w_wr_row;
    logic [NCOL*AW-1:0]    w_rd_row;
    logic [NCOL*OUT_W-1:0] w_lane_data;
    logic [NCOL-1:0]       w_lane_sat;
    logic                  w_last_row;
    logic                  w_last_pass;
    logic                  w_adv;
    logic                  w_lane_en;
    logic                  w_issue;
    logic                  w_accept;
    logic                  w_last_out;

    assign w_last_row  = (RW'(r_row_cnt) == r_rows - RW'(1));
    assign w_last_pass = (r_pass_cnt == r_passes - PASS_W'(1));
    assign w_adv       = !r_out_vld || bus.out_rdy;
    assign w_lane_en   = (r_state == ST_DRAIN) && w_adv;
    assign w_issue     = w_lane_en && (r_rd_row < r_rows);
    assign w_accept    = (r_state == ST_DRAIN) && r_out_vld && bus.out_rdy;
    assign w_last_out  = (r_out_cnt == r_rows - RW'(1));
    assign w_rd_row    = r_buf[r_rd_row[AIW-1:0]];

    // Pass 0 overwrites, so stale buffer contents never leak into a tile.
    always_comb begin
        w_wr_row = '0;
        for (int k = 0; k < NCOL; k++) begin
            w_wr_row[k*AW +: AW] = ((r_pass_cnt == '0) ? '0 : r_buf[r_row_cnt][k*AW +: AW])
                                   + sext_psum(bus.psum_i[k*IW +: IW]);
        end
    end

    always_ff @(posedge clk) begin
        if ((r_state == ST_ACC) && bus.psum_vld) begin
            r_buf[r_row_cnt] <= w_wr_row;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rows     <= '0;
            r_passes   <= '0;
            r_mult     <= '0;
            r_shift    <= '0;
            r_relu     <= 1'b0;
            r_row_cnt  <= '0;
            r_pass_cnt <= '0;
            r_rd_row   <= '0;
            r_out_cnt  <= '0;
            r_s1_vld   <= 1'b0;
            r_out_vld  <= 1'b0;
            r_done     <= 1'b0;
            r_sat      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.psum_vld && (r_state != ST_ACC)) begin
                r_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (bus.cfg_start) begin
                        r_rows     <= bus.cfg_rows;
                        r_passes   <= bus.cfg_passes;
                        r_mult     <= bus.cfg_mult;
                        r_shift    <= bus.cfg_shift;
                        r_relu     <= bus.cfg_relu;
                        r_row_cnt  <= '0;
                        r_pass_cnt <= '0;
                        r_sat      <= 1'b0;
                        r_err      <= bus.psum_vld;
                        r_state    <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (bus.psum_vld) begin
                        if (w_last_row) begin
                            r_row_cnt <= '0;
                            if (w_last_pass) begin
                                r_state   <= ST_DRAIN;
                                r_rd_row  <= '0;
                                r_out_cnt <= '0;
                                r_s1_vld  <= 1'b0;
                            end else begin
                                r_pass_cnt <= r_pass_cnt + PASS_W'(1);
                            end
                        end else begin
                            r_row_cnt <= r_row_cnt + AIW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // S1 and S2 shift together whenever the output slot frees up.
                    if (w_lane_en) begin
                        r_s1_vld  <= w_issue;
                        r_out_vld <= r_s1_vld;
                        if (r_s1_vld) begin
                            r_sat <= r_sat | (|w_lane_sat);
                        end
                        if (w_issue) begin
                            r_rd_row <= r_rd_row + RW'(1);
                        end
                    end
                    if (w_accept) begin
                        r_out_cnt <= r_out_cnt + RW'(1);
                        if (w_last_out) begin
                            r_done    <= 1'b1;
                            r_state   <= ST_IDLE;
                            r_out_vld <= 1'b0;
                            r_s1_vld  <= 1'b0;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    generate
        for (genvar k = 0; k < NCOL; k++) begin : g_lane
            requant_lane u_lane (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_en    (w_lane_en),
                .i_acc   (w_rd_row[k*AW +: AW]),
                .i_mult  (r_mult),
                .i_shift (r_shift),
                .i_relu  (r_relu),
                .o_data  (w_lane_data[k*OUT_W +: OUT_W]),
                .o_sat   (w_lane_sat[k])
            );
        end
    endgenerate

    assign bus.out_vld  = r_out_vld;
    assign bus.out_data = w_lane_data;
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.done     = r_done;
    assign bus.sat_flag = r_sat;
    assign bus.err_flag = r_err;

endmodule
`default_nettype wire
